// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and default latencies for the cache access
//               completion controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

  // Controller phases; IDLE and DONE are the only states that accept requests
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HIT_WAIT = 3'd1,
    WB       = 3'd2,
    FILL     = 3'd3,
    DONE     = 3'd4
  } done_state_t;

  localparam int DEF_HIT_CYCLES  = 2;
  localparam int DEF_MISS_CYCLES = 3;
  localparam int DEF_WB_CYCLES   = 2;
  localparam int DEF_STAT_W      = 16;

  // Largest of three latencies, used to size the shared down-counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_done_ctrl_component_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : component_down_counter
// Description : Loadable down-counter with zero flag. Load has priority over
//               decrement; decrementing at zero is never requested by the
//               controller, so no underflow guard is needed.
// Revision    : 1.0 - initial release
// ============================================================================
module component_down_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  // Count register: load wins over decrement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/cache_done_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_done_ctrl
// Description : Cache access completion controller. Accepts one request at a
//               time, classifies it as hit / clean miss / dirty miss, times
//               the access phases with a shared down-counter, and produces a
//               one-cycle done pulse plus saturating hit/miss statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_done_ctrl
  import cache_pkg::*;
#(
  parameter int HIT_CYCLES  = DEF_HIT_CYCLES,
  parameter int MISS_CYCLES = DEF_MISS_CYCLES,
  parameter int WB_CYCLES   = DEF_WB_CYCLES,
  parameter int STAT_W      = DEF_STAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re,
  input  logic              we,
  input  logic              hit,
  input  logic              dirty,
  input  logic              stat_clr,
  output logic              busy,
  output logic              done,
  output logic              done_write,
  output logic              wb_active,
  output logic              fill_active,
  output logic              err,
  output logic [STAT_W-1:0] hit_cnt,
  output logic [STAT_W-1:0] miss_cnt
);

  localparam int CNT_W = $clog2(max3(HIT_CYCLES, MISS_CYCLES, WB_CYCLES) + 1);

  // Counter preload values: a phase of N edges starts at N-1 and ends on zero
  localparam logic [CNT_W-1:0] HIT_LOAD  = CNT_W'(HIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] MISS_LOAD = CNT_W'(MISS_CYCLES - 1);
  localparam logic [CNT_W-1:0] WB_LOAD   = CNT_W'(WB_CYCLES - 1);

  done_state_t      state;
  done_state_t      next_state;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             accept;
  logic             op_write;

  // A request is taken only while not busy; DONE accepts for back-to-back use
  assign accept = ((state == IDLE) || (state == DONE)) && (re || we);

  component_down_counter #(
    .WIDTH (CNT_W)
  ) u_down_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Next-state and counter control; one counter is reused across all phases
  always_comb begin
    next_state   = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          cnt_load = 1'b1;
          if (hit) begin
            next_state   = HIT_WAIT;
            cnt_load_val = HIT_LOAD;
          end else if (dirty) begin
            next_state   = WB;
            cnt_load_val = WB_LOAD;
          end else begin
            next_state   = FILL;
            cnt_load_val = MISS_LOAD;
          end
        end else begin
          next_state = IDLE;
        end
      end
      HIT_WAIT, FILL: begin
        if (cnt_zero) begin
          next_state = DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      WB: begin
        if (cnt_zero) begin
          next_state   = FILL;
          cnt_load     = 1'b1;
          cnt_load_val = MISS_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Operation type and conflict flag captured at accept; a re+we conflict
  // completes as a read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_write <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= accept && re && we;
      if (accept) begin
        op_write <= we && !re;
      end
    end
  end

  // Hit statistic: saturating, clear has priority over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt <= '0;
    end else if (stat_clr) begin
      hit_cnt <= '0;
    end else if (accept && hit && (hit_cnt != '1)) begin
      hit_cnt <= hit_cnt + 1'b1;
    end
  end

  // Miss statistic: saturating, clear has priority over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt <= '0;
    end else if (stat_clr) begin
      miss_cnt <= '0;
    end else if (accept && !hit && (miss_cnt != '1)) begin
      miss_cnt <= miss_cnt + 1'b1;
    end
  end

  assign busy        = (state == HIT_WAIT) || (state == WB) || (state == FILL);
  assign done        = (state == DONE);
  assign done_write  = (state == DONE) && op_write;
  assign wb_active   = (state == WB);
  assign fill_active = (state == FILL);

endmodule
`default_nettype wire

// File: tb/tb_cache_done_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_done_ctrl
// Description : Self-checking bench for cache_done_ctrl. A hand-derived vector
//               table, directed corner sequences and random stimulus compared
//               against a phase-schedule reference model. A second instance
//               with 2-bit statistics exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_done_ctrl;

  localparam int HIT_C  = 2;
  localparam int MISS_C = 3;
  localparam int WB_C   = 2;

  logic clk = 1'b0;
  logic rst_n, re, we, hit, dirty, stat_clr;

  logic        busy, done, done_write, wb_active, fill_active, err;
  logic [15:0] hit_cnt, miss_cnt;
  logic        busy_s, done_s, done_write_s, wb_active_s, fill_active_s, err_s;
  logic [1:0]  hit_cnt_s, miss_cnt_s;

  cache_done_ctrl #(
    .HIT_CYCLES (HIT_C), .MISS_CYCLES (MISS_C), .WB_CYCLES (WB_C), .STAT_W (16)
  ) u_dut (
    .clk (clk), .rst_n (rst_n), .re (re), .we (we), .hit (hit), .dirty (dirty),
    .stat_clr (stat_clr), .busy (busy), .done (done), .done_write (done_write),
    .wb_active (wb_active), .fill_active (fill_active), .err (err),
    .hit_cnt (hit_cnt), .miss_cnt (miss_cnt)
  );

  cache_done_ctrl #(
    .HIT_CYCLES (HIT_C), .MISS_CYCLES (MISS_C), .WB_CYCLES (WB_C), .STAT_W (2)
  ) u_dut_s (
    .clk (clk), .rst_n (rst_n), .re (re), .we (we), .hit (hit), .dirty (dirty),
    .stat_clr (stat_clr), .busy (busy_s), .done (done_s), .done_write (done_write_s),
    .wb_active (wb_active_s), .fill_active (fill_active_s), .err (err_s),
    .hit_cnt (hit_cnt_s), .miss_cnt (miss_cnt_s)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: queue of upcoming cycle phases --------
  localparam int P_IDLE = 0, P_HW = 1, P_WB = 2, P_FILL = 3, P_DONE = 4;
  int          sched[$];
  int unsigned m_hit, m_miss, m_hit_s, m_miss_s;
  bit          m_err, m_dw;

  task automatic model_reset();
    sched.delete();
    m_hit = 0; m_miss = 0; m_hit_s = 0; m_miss_s = 0;
    m_err = 0; m_dw = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at the edge
  task automatic model_edge();
    int  cur;
    bit  was_busy;
    cur = (sched.size() != 0) ? sched[0] : P_IDLE;
    if (sched.size() != 0) void'(sched.pop_front());
    was_busy = (cur == P_HW) || (cur == P_WB) || (cur == P_FILL);
    m_err = 0;
    if (stat_clr) begin
      m_hit = 0; m_miss = 0; m_hit_s = 0; m_miss_s = 0;
    end
    if (!was_busy && (re || we)) begin
      if (hit) begin
        repeat (HIT_C) sched.push_back(P_HW);
        if (!stat_clr) begin
          if (m_hit < 65535) m_hit++;
          if (m_hit_s < 3) m_hit_s++;
        end
      end else begin
        if (dirty) repeat (WB_C) sched.push_back(P_WB);
        repeat (MISS_C) sched.push_back(P_FILL);
        if (!stat_clr) begin
          if (m_miss < 65535) m_miss++;
          if (m_miss_s < 3) m_miss_s++;
        end
      end
      sched.push_back(P_DONE);
      m_dw  = we && !re;
      m_err = re && we;
    end
  endtask

  task automatic check_model(input string tag);
    int  e;
    bit  eb;
    e  = (sched.size() != 0) ? sched[0] : P_IDLE;
    eb = (e == P_HW) || (e == P_WB) || (e == P_FILL);
    chk({tag, "_busy"}, busy, eb);
    chk({tag, "_done"}, done, e == P_DONE);
    chk({tag, "_dw"},   done_write, (e == P_DONE) && m_dw);
    chk({tag, "_wb"},   wb_active, e == P_WB);
    chk({tag, "_fill"}, fill_active, e == P_FILL);
    chk({tag, "_err"},  err, m_err);
    chk({tag, "_hitc"}, hit_cnt, m_hit);
    chk({tag, "_missc"}, miss_cnt, m_miss);
    chk({tag, "_done_s"}, done_s, e == P_DONE);
    chk({tag, "_hitc_s"}, hit_cnt_s, m_hit_s);
    chk({tag, "_missc_s"}, miss_cnt_s, m_miss_s);
  endtask

  task automatic drive(input bit r, input bit w, input bit h, input bit d, input bit c);
    re = r; we = w; hit = h; dirty = d; stat_clr = c;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- hand-derived vector table ------------------------------
  typedef struct packed {
    bit re, we, hit, dirty;
    bit busy, done, dw, wb, fill, err;
  } vec_t;

  vec_t tab [0:14];
  int   dones;

  initial begin
    // hit read (rows 0-3), dirty-miss write (4-10), re&we conflict hit (11-14);
    // requests presented while busy (rows 1, 12) must be ignored
    tab[0]  = '{1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
    tab[1]  = '{1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
    tab[2]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0};
    tab[3]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    tab[4]  = '{1'b0,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0};
    tab[5]  = '{1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0};
    tab[6]  = '{1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0};
    tab[7]  = '{1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0};
    tab[8]  = '{1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0};
    tab[9]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0};
    tab[10] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    tab[11] = '{1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1};
    tab[12] = '{1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
    tab[13] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0};
    tab[14] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};

    model_reset();
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hitc", hit_cnt, 0);
    chk("rst_missc", miss_cnt, 0);
    rst_n = 1'b1;
    #4;

    // table-driven sequences
    for (int i = 0; i < 15; i++) begin
      drive(tab[i].re, tab[i].we, tab[i].hit, tab[i].dirty, 1'b0);
      step();
      chk($sformatf("tab%0d_busy", i), busy, tab[i].busy);
      chk($sformatf("tab%0d_done", i), done, tab[i].done);
      chk($sformatf("tab%0d_dw", i),   done_write, tab[i].dw);
      chk($sformatf("tab%0d_wb", i),   wb_active, tab[i].wb);
      chk($sformatf("tab%0d_fill", i), fill_active, tab[i].fill);
      chk($sformatf("tab%0d_err", i),  err, tab[i].err);
    end
    chk("tab_hitc", hit_cnt, 2);
    chk("tab_missc", miss_cnt, 1);
    check_model("tab_end");

    // continuous clean-miss reads: back-to-back acceptance in the done cycle
    dones = 0;
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step();
      check_model("b2b");
      if (done) dones++;
    end
    chk("b2b_dones", dones, 4);
    chk("b2b_missc", miss_cnt, 5);

    // asynchronous reset in the middle of a writeback
    drive(0, 0, 0, 0, 0);
    repeat (6) step();
    drive(0, 1, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0);
    chk("pre_rst_wb", wb_active, 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_busy", busy, 0);
    chk("arst_wb", wb_active, 0);
    chk("arst_hitc", hit_cnt, 0);
    chk("arst_missc", miss_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      check_model("post_rst");
      if (done) dones++;
    end
    chk("post_rst_no_done", dones, 0);

    // five hits: 2-bit statistic saturates, then clear beats a concurrent hit
    drive(1, 0, 1, 0, 0);
    for (int i = 0; i < 15; i++) begin
      step();
      check_model("sat");
    end
    chk("sat_hitc_s", hit_cnt_s, 3);
    chk("sat_hitc", hit_cnt, 5);
    drive(1, 0, 1, 0, 1);
    step();
    check_model("clr");
    chk("clr_hitc_s", hit_cnt_s, 0);
    chk("clr_hitc", hit_cnt, 0);
    chk("clr_busy", busy, 1);

    // randomized stimulus against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 24) == 0);
      step();
      check_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
